// File: rtl/fsm_state_monitor.sv
`default_nettype none
// ============================================================================
// Module      : fsm_state_monitor
// Description : Receiver/checker for the 8-bit sync-block FSM state bus.
//               Samples the state code every clock, checks each transition
//               against the legal IDLE..DETECTOR_FINISHED sequence, measures
//               per-state dwell time, counts completed and aborted acquisition
//               cycles and keeps sticky error flags for readout.
//               Optional macro FSM_MON_HISTORY_EN adds an 8-deep transition
//               history FIFO with its read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_state_monitor #(
   parameter int DWELL_W        = 24,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int COUNT_W        = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [7:0]         state_in,
   input  logic               err_clear,
   output logic [7:0]         cur_state,
   output logic [7:0]         prev_state,
   output logic [DWELL_W-1:0] dwell_count,
   output logic [COUNT_W-1:0] cycle_count,
   output logic [COUNT_W-1:0] abort_count,
   output logic               illegal_pulse,
   output logic               timeout_pulse,
   output logic               err_illegal,
   output logic               err_badcode,
`ifdef FSM_MON_HISTORY_EN
   input  logic               hist_rd,
   output logic               hist_valid,
   output logic [15:0]        hist_data,
   output logic               hist_overflow,
`endif
   output logic               err_timeout
);

   localparam logic [7:0]         c_idle        = 8'd0;
   localparam logic [7:0]         c_last        = 8'd8;
   localparam logic [DWELL_W-1:0] c_dwell_max   = '1;
   localparam logic [DWELL_W-1:0] c_timeout_hit = DWELL_W'(TIMEOUT_CYCLES - 1);

   // Registered state
   logic [7:0]         cur_state_q,     cur_state_d;
   logic [7:0]         prev_state_q,    prev_state_d;
   logic [DWELL_W-1:0] dwell_q,         dwell_d;
   logic [COUNT_W-1:0] cycle_q,         cycle_d;
   logic [COUNT_W-1:0] abort_q,         abort_d;
   logic               illegal_pulse_q, illegal_pulse_d;
   logic               timeout_pulse_q, timeout_pulse_d;
   logic               err_illegal_q,   err_illegal_d;
   logic               err_badcode_q,   err_badcode_d;
   logic               err_timeout_q,   err_timeout_d;

   // Event decode
   logic w_change;
   logic w_in_bad;
   logic w_step_ok;
   logic w_to_idle;
   logic w_illegal;
   logic w_badcode;
   logic w_cycle_done;
   logic w_abort;
   logic w_timeout;

   // Classify the sampled code against the currently held state
   always_comb begin
      w_change     = (state_in != cur_state_q);
      w_in_bad     = (state_in > c_last);
      w_step_ok    = (cur_state_q < c_last) && (state_in == (cur_state_q + 8'd1));
      w_to_idle    = (state_in == c_idle);
      // Any return to IDLE is legal; only 8->0 completes a cycle and only
      // 1..7->0 is an abort (leaving a bad code for IDLE counts as neither).
      w_illegal    = w_change && !(w_step_ok || w_to_idle);
      w_badcode    = w_change && w_in_bad;
      w_cycle_done = w_change && w_to_idle && (cur_state_q == c_last);
      w_abort      = w_change && w_to_idle && (cur_state_q != c_idle) &&
                     (cur_state_q < c_last);
      // A change on the same edge wins over a pending timeout
      w_timeout    = !w_change && (cur_state_q != c_idle) &&
                     (dwell_q == c_timeout_hit);
   end

   // Next-state values for tracking, counters, pulses and sticky flags
   always_comb begin
      cur_state_d     = cur_state_q;
      prev_state_d    = prev_state_q;
      dwell_d         = dwell_q;
      cycle_d         = cycle_q;
      abort_d         = abort_q;
      illegal_pulse_d = w_illegal;
      timeout_pulse_d = w_timeout;

      if (w_change) begin
         prev_state_d = cur_state_q;
         cur_state_d  = state_in;
         dwell_d      = '0;
      end else if (dwell_q != c_dwell_max) begin
         dwell_d = dwell_q + DWELL_W'(1);
      end

      if (w_cycle_done) begin
         cycle_d = cycle_q + COUNT_W'(1);
      end
      if (w_abort) begin
         abort_d = abort_q + COUNT_W'(1);
      end

      // Set has priority over a coincident clear
      err_illegal_d = (err_illegal_q & ~err_clear) | w_illegal;
      err_badcode_d = (err_badcode_q & ~err_clear) | w_badcode;
      err_timeout_d = (err_timeout_q & ~err_clear) | w_timeout;
   end

   // Monitor registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur_state_q     <= c_idle;
         prev_state_q    <= c_idle;
         dwell_q         <= '0;
         cycle_q         <= '0;
         abort_q         <= '0;
         illegal_pulse_q <= 1'b0;
         timeout_pulse_q <= 1'b0;
         err_illegal_q   <= 1'b0;
         err_badcode_q   <= 1'b0;
         err_timeout_q   <= 1'b0;
      end else begin
         cur_state_q     <= cur_state_d;
         prev_state_q    <= prev_state_d;
         dwell_q         <= dwell_d;
         cycle_q         <= cycle_d;
         abort_q         <= abort_d;
         illegal_pulse_q <= illegal_pulse_d;
         timeout_pulse_q <= timeout_pulse_d;
         err_illegal_q   <= err_illegal_d;
         err_badcode_q   <= err_badcode_d;
         err_timeout_q   <= err_timeout_d;
      end
   end

   assign cur_state     = cur_state_q;
   assign prev_state    = prev_state_q;
   assign dwell_count   = dwell_q;
   assign cycle_count   = cycle_q;
   assign abort_count   = abort_q;
   assign illegal_pulse = illegal_pulse_q;
   assign timeout_pulse = timeout_pulse_q;
   assign err_illegal   = err_illegal_q;
   assign err_badcode   = err_badcode_q;
   assign err_timeout   = err_timeout_q;

`ifdef FSM_MON_HISTORY_EN
   logic [15:0] hist_mem_q [8];
   logic [2:0]  hist_wr_q,  hist_wr_d;
   logic [2:0]  hist_rd_q,  hist_rd_d;
   logic [3:0]  hist_cnt_q, hist_cnt_d;
   logic        hist_ovf_q, hist_ovf_d;
   logic        w_push;
   logic        w_pop;
   logic        w_full;

   // FIFO pointer and occupancy update; a push into a full FIFO without a
   // pop overwrites the oldest entry and drags the read pointer along
   always_comb begin
      w_push     = w_change;
      w_pop      = hist_rd && (hist_cnt_q != 4'd0);
      w_full     = (hist_cnt_q == 4'd8);
      hist_wr_d  = hist_wr_q;
      hist_rd_d  = hist_rd_q;
      hist_cnt_d = hist_cnt_q;
      hist_ovf_d = (hist_ovf_q & ~err_clear) | (w_push && w_full && !w_pop);

      if (w_push && w_pop) begin
         hist_wr_d = hist_wr_q + 3'd1;
         hist_rd_d = hist_rd_q + 3'd1;
      end else if (w_push) begin
         hist_wr_d = hist_wr_q + 3'd1;
         if (w_full) begin
            hist_rd_d = hist_rd_q + 3'd1;
         end else begin
            hist_cnt_d = hist_cnt_q + 4'd1;
         end
      end else if (w_pop) begin
         hist_rd_d  = hist_rd_q + 3'd1;
         hist_cnt_d = hist_cnt_q - 4'd1;
      end
   end

   // FIFO control registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hist_wr_q  <= 3'd0;
         hist_rd_q  <= 3'd0;
         hist_cnt_q <= 4'd0;
         hist_ovf_q <= 1'b0;
      end else begin
         hist_wr_q  <= hist_wr_d;
         hist_rd_q  <= hist_rd_d;
         hist_cnt_q <= hist_cnt_d;
         hist_ovf_q <= hist_ovf_d;
      end
   end

   // FIFO storage: each accepted change records {old state, new state}
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) begin
            hist_mem_q[i] <= 16'd0;
         end
      end else if (w_push) begin
         hist_mem_q[hist_wr_q] <= {cur_state_q, state_in};
      end
   end

   assign hist_valid    = (hist_cnt_q != 4'd0);
   assign hist_data     = hist_mem_q[hist_rd_q];
   assign hist_overflow = hist_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_state_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_state_monitor
// Description : Self-checking bench for fsm_state_monitor: a table of
//               single-cycle transition vectors plus hand-written sequences
//               for full cycles, timeouts, counter wrap, async reset and the
//               optional history FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_state_monitor;

   localparam int DW = 5;
   localparam int CW = 3;
   localparam int TO = 16;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [7:0]    state_in;
   logic          err_clear;
   logic [7:0]    cur_state;
   logic [7:0]    prev_state;
   logic [DW-1:0] dwell_count;
   logic [CW-1:0] cycle_count;
   logic [CW-1:0] abort_count;
   logic          illegal_pulse;
   logic          timeout_pulse;
   logic          err_illegal;
   logic          err_badcode;
   logic          err_timeout;
`ifdef FSM_MON_HISTORY_EN
   logic          hist_rd;
   logic          hist_valid;
   logic [15:0]   hist_data;
   logic          hist_overflow;
`endif

   int n_checks = 0;
   int n_err    = 0;
   int n_ill_p  = 0;
   int n_to_p   = 0;

   fsm_state_monitor #(
      .DWELL_W       (DW),
      .TIMEOUT_CYCLES(TO),
      .COUNT_W       (CW)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .state_in     (state_in),
      .err_clear    (err_clear),
      .cur_state    (cur_state),
      .prev_state   (prev_state),
      .dwell_count  (dwell_count),
      .cycle_count  (cycle_count),
      .abort_count  (abort_count),
      .illegal_pulse(illegal_pulse),
      .timeout_pulse(timeout_pulse),
      .err_illegal  (err_illegal),
      .err_badcode  (err_badcode),
`ifdef FSM_MON_HISTORY_EN
      .hist_rd      (hist_rd),
      .hist_valid   (hist_valid),
      .hist_data    (hist_data),
      .hist_overflow(hist_overflow),
`endif
      .err_timeout  (err_timeout)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] st;
      logic       clr;
      logic [7:0] cur;
      logic [7:0] prv;
      int         dw;
      logic       ip;
      logic       ie;
      logic       bad;
      int         cyc;
      int         abt;
   } vec_t;

   vec_t tv[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one clock of input and sample just after the edge
   task automatic step(input logic [7:0] s, input logic clr);
      state_in  = s;
      err_clear = clr;
      @(posedge clock);
      #1;
      if (illegal_pulse) n_ill_p++;
      if (timeout_pulse) n_to_p++;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " cur"},   32'(cur_state), 0);
      check({tag, " prev"},  32'(prev_state), 0);
      check({tag, " dwell"}, 32'(dwell_count), 0);
      check({tag, " cyc"},   32'(cycle_count), 0);
      check({tag, " abt"},   32'(abort_count), 0);
      check({tag, " flags"}, 32'({illegal_pulse, timeout_pulse, err_illegal, err_badcode, err_timeout}), 0);
   endtask

   initial begin
      int ill_before;
      int exp_abt;
      logic [15:0] exp_hist [8];

      // st   clr  cur   prv   dw ip ie bad cyc abt
      tv[0]  = '{8'd0,  1'b0, 8'd0,  8'd0,  1, 1'b0, 1'b0, 1'b0, 0, 0};
      tv[1]  = '{8'd1,  1'b0, 8'd1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 0, 0};
      tv[2]  = '{8'd2,  1'b0, 8'd2,  8'd1,  0, 1'b0, 1'b0, 1'b0, 0, 0};
      tv[3]  = '{8'd2,  1'b0, 8'd2,  8'd1,  1, 1'b0, 1'b0, 1'b0, 0, 0};
      tv[4]  = '{8'd0,  1'b0, 8'd0,  8'd2,  0, 1'b0, 1'b0, 1'b0, 0, 1};
      tv[5]  = '{8'd1,  1'b0, 8'd1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 0, 1};
      tv[6]  = '{8'd3,  1'b0, 8'd3,  8'd1,  0, 1'b1, 1'b1, 1'b0, 0, 1};
      tv[7]  = '{8'd3,  1'b0, 8'd3,  8'd1,  1, 1'b0, 1'b1, 1'b0, 0, 1};
      tv[8]  = '{8'd3,  1'b1, 8'd3,  8'd1,  2, 1'b0, 1'b0, 1'b0, 0, 1};
      tv[9]  = '{8'd2,  1'b0, 8'd2,  8'd3,  0, 1'b1, 1'b1, 1'b0, 0, 1};
      tv[10] = '{8'd12, 1'b0, 8'd12, 8'd2,  0, 1'b1, 1'b1, 1'b1, 0, 1};
      tv[11] = '{8'd0,  1'b0, 8'd0,  8'd12, 0, 1'b0, 1'b1, 1'b1, 0, 1};
      tv[12] = '{8'd0,  1'b1, 8'd0,  8'd12, 1, 1'b0, 1'b0, 1'b0, 0, 1};
      tv[13] = '{8'd5,  1'b1, 8'd5,  8'd0,  0, 1'b1, 1'b1, 1'b0, 0, 1};
      tv[14] = '{8'd0,  1'b0, 8'd0,  8'd5,  0, 1'b0, 1'b1, 1'b0, 0, 2};
      tv[15] = '{8'd0,  1'b1, 8'd0,  8'd5,  1, 1'b0, 1'b0, 1'b0, 0, 2};

      exp_hist[0] = 16'h0203; exp_hist[1] = 16'h0304;
      exp_hist[2] = 16'h0405; exp_hist[3] = 16'h0506;
      exp_hist[4] = 16'h0607; exp_hist[5] = 16'h0708;
      exp_hist[6] = 16'h0800; exp_hist[7] = 16'h0001;

      reset_n   = 1'b0;
      state_in  = 8'd0;
      err_clear = 1'b0;
`ifdef FSM_MON_HISTORY_EN
      hist_rd   = 1'b0;
`endif
      repeat (2) @(posedge clock);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;

      // Single-cycle transition vectors
      for (int i = 0; i < 16; i++) begin
         step(tv[i].st, tv[i].clr);
         check($sformatf("v%0d cur", i),  32'(cur_state),     32'(tv[i].cur));
         check($sformatf("v%0d prev", i), 32'(prev_state),    32'(tv[i].prv));
         check($sformatf("v%0d dwell", i), 32'(dwell_count),  tv[i].dw);
         check($sformatf("v%0d ill_p", i), 32'(illegal_pulse), 32'(tv[i].ip));
         check($sformatf("v%0d err_ill", i), 32'(err_illegal), 32'(tv[i].ie));
         check($sformatf("v%0d err_bad", i), 32'(err_badcode), 32'(tv[i].bad));
         check($sformatf("v%0d cyc", i),  32'(cycle_count),   tv[i].cyc);
         check($sformatf("v%0d abt", i),  32'(abort_count),   tv[i].abt);
      end

      // Full acquisition cycle, 10 cycles per state
      ill_before = n_ill_p;
      n_to_p     = 0;
      for (int s = 1; s <= 8; s++) begin
         repeat (10) step(8'(s), 1'b0);
      end
      step(8'd0, 1'b0);
      check("full cyc",   32'(cycle_count), 1);
      check("full abt",   32'(abort_count), 2);
      check("full cur",   32'(cur_state), 0);
      check("full prev",  32'(prev_state), 8);
      check("full flags", 32'({err_illegal, err_badcode, err_timeout}), 0);
      check("full pulses", 32'(n_ill_p - ill_before + n_to_p), 0);

      // Change on the would-be timeout edge suppresses the timeout
      step(8'd1, 1'b0);
      repeat (15) step(8'd1, 1'b0);
      check("pre_to dwell", 32'(dwell_count), 15);
      step(8'd2, 1'b0);
      check("supp to_p",  32'(timeout_pulse), 0);
      check("supp err_to", 32'(err_timeout), 0);
      check("supp dwell", 32'(dwell_count), 0);

      // Hold at 6: one timeout, then dwell saturates
      step(8'd3, 1'b0); step(8'd4, 1'b0); step(8'd5, 1'b0); step(8'd6, 1'b0);
      n_to_p = 0;
      for (int k = 1; k <= 20; k++) begin
         step(8'd6, 1'b0);
         check($sformatf("hold%0d dwell", k), 32'(dwell_count), 32'(k));
         check($sformatf("hold%0d to_p", k), 32'(timeout_pulse), 32'(k == 16));
      end
      check("hold err_to", 32'(err_timeout), 1);
      repeat (20) step(8'd6, 1'b0);
      check("sat dwell", 32'(dwell_count), 31);
      check("to once", 32'(n_to_p), 1);
      step(8'd6, 1'b1);
      check("clr err_to", 32'(err_timeout), 0);
      step(8'd0, 1'b0);
      check("abort6 abt", 32'(abort_count), 3);
      check("abort6 ill", 32'(err_illegal), 0);

      // Abort counter wraps at 2^CW
      exp_abt = 3;
      for (int i = 0; i < 6; i++) begin
         step(8'd1, 1'b0);
         step(8'd0, 1'b0);
         exp_abt++;
         check($sformatf("wrap%0d abt", i), 32'(abort_count), 32'(exp_abt % 8));
      end

      // Asynchronous reset in state 4 with err_illegal set
      step(8'd2, 1'b0);
      step(8'd3, 1'b0);
      step(8'd4, 1'b0);
      check("pre_rst cur", 32'(cur_state), 4);
      check("pre_rst ill", 32'(err_illegal), 1);
      #3 reset_n = 1'b0;
      #1;
      check_all_zero("async");
      #2 reset_n = 1'b1;
      step(8'd0, 1'b0);
      step(8'd1, 1'b0);
      check("post cur",  32'(cur_state), 1);
      check("post prev", 32'(prev_state), 0);
      check("post errs", 32'({illegal_pulse, err_illegal, err_badcode, err_timeout}), 0);

`ifdef FSM_MON_HISTORY_EN
      // History FIFO: 10 pushes, keep the last 8
      #3 reset_n = 1'b0;
      #2 reset_n = 1'b1;
      for (int s = 1; s <= 8; s++) step(8'(s), 1'b0);
      step(8'd0, 1'b0);
      step(8'd1, 1'b0);
      check("hist ovf", 32'(hist_overflow), 1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("hist%0d valid", i), 32'(hist_valid), 1);
         check($sformatf("hist%0d data", i), 32'(hist_data), 32'(exp_hist[i]));
         hist_rd = 1'b1;
         step(8'd1, 1'b0);
         hist_rd = 1'b0;
      end
      check("hist empty", 32'(hist_valid), 0);
      step(8'd1, 1'b1);
      check("hist ovf clr", 32'(hist_overflow), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
